ps2_key_event_ctrl: RTL and testbench
=====================================

Name: ps2_key_event_ctrl

Overview:
- Sequences raw PS/2 scan bytes into complete key events: {code, extended, released}.
- Handles the E0 (extended) and F0 (break) prefixes, suppresses typematic repeats and drops keyboard control bytes.
- Buffers events in a small first-word-fall-through queue with a valid/ack handshake.
- Sits between the PS/2 byte receiver (`ready` pulse plus byte) and consumers such as display, keypad decoding and control FSMs.

Parameters:
- FIFO_DEPTH, 4: event queue depth; must be a power of two, >= 2.
- TIMEOUT_CYC, 1000000: idle cycles after a prefix before the partial sequence is abandoned (10 ms at 100 MHz); must be >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- codigo_tecla  in  8  scan byte from receiver; valid only when `ready`=1.
- ready  in  1  one-cycle strobe, byte available.
- evt_valid  out  1  queue not empty; head event is presented.
- evt_code  out  8  head event scan code (prefixes stripped).
- evt_ext  out  1  head event had E0 prefix.
- evt_release  out  1  head event is a break (key released).
- evt_ack  in  1  consumer pops head; ignored when evt_valid=0.
- fifo_level  out  clog2(FIFO_DEPTH)+1  entries queued.
- overflow  out  1  sticky; event dropped because queue was full.

Behaviour:
- Interface: one clock, `clk`. Reset is `reset`, synchronous and active-high.
- Reset values:
  - state=IDLE, queue empty, fifo_level=0.
  - evt_valid=0, evt_code=0, evt_ext=0, evt_release=0.
  - overflow=0, held_valid=0, timeout counter=0.
- Reset mid-sequence discards any partial prefix and all queued events.
- `ready` is sampled on rising clk. Bytes are processed only when ready=1; codigo_tecla is don't-care otherwise.
- FSM states are IDLE, EXT, BRK, EXT_BRK. On ready=1:
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - Control bytes 00, AA, EE, FA, FC, FE, FF -> discarded, stay IDLE.
    - Any other byte -> make event, ext=0, stay IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - E0 -> stay EXT (duplicate prefix ignored).
    - Other -> make event, ext=1 -> IDLE.
  - BRK:
    - E0 or F0 -> protocol error: no event -> IDLE.
    - Other -> release event, ext=0 -> IDLE.
  - EXT_BRK:
    - E0 or F0 -> no event -> IDLE.
    - Other -> release event, ext=1 -> IDLE.
- Timeout:
  - In any non-IDLE state, the counter increments on each cycle with ready=0.
  - On reaching TIMEOUT_CYC-1 the FSM goes to IDLE, emits no event and clears the counter.
  - Counter is cleared on every ready=1 and whenever the FSM is in IDLE.
- Typematic suppression:
  - Register {held_code, held_ext, held_valid} tracks the last key pressed.
  - A make event matching held_code/held_ext while held_valid=1 is suppressed (not queued).
  - Any other make is queued, loads held_code/held_ext and sets held_valid.
  - A release matching held clears held_valid.
  - Releases are always queued.
- Queue:
  - Entry is 10 bits: {ext, release, code}.
  - An event is written on the same edge that samples the completing byte. evt_valid rises in the following cycle; latency from ready to evt_valid is 1 cycle when the queue is empty.
  - Head outputs are first-word-fall-through; they are 0 when empty.
  - evt_ack=1 with evt_valid=1 pops on that edge; the next entry appears next cycle.
  - Push while full without a pop: event dropped, overflow<=1 (sticky until reset), queue unchanged.
  - Push and pop in the same cycle:
    - When full, both succeed and level is unchanged.
    - When empty, only the push applies; ack is ignored.
- Read and write pointers wrap modulo FIFO_DEPTH. fifo_level is exact, 0..FIFO_DEPTH.

Test Plan:
1. Make/break: bytes 1C, F0, 1C with evt_ack tied high -> events {1C,ext0,rel0} then {1C,ext0,rel1}; evt_valid high 1 cycle after each completing ready; fifo_level returns to 0.
2. Extended key: E0 75, then E0 F0 75 -> events {75,1,0} and {75,1,1}. Also E0 E0 75 -> single {75,1,0}. AA and FA alone -> no event.
3. Typematic: 1C x5, then F0 1C, then 1C -> exactly three events: make 1C, release 1C, make 1C. Also 1C, 32, 1C -> three makes, since held changes to 32.
4. Overflow: FIFO_DEPTH=4, evt_ack=0, makes 15,1D,24,2D,2C -> fifo_level=4, overflow=1, head=15. Then ack pop order is 15,1D,24,2D. Also push with ack at full -> level stays 4, overflow unchanged.
5. Timeout: TIMEOUT_CYC=16, E0 then 16 idle cycles, then 1C -> {1C,ext0}. With 14 idle cycles instead, 1C -> {1C,ext1}.
6. Reset mid-operation: queue 2 events, send F0, assert reset 1 cycle, then send 1C -> evt_valid=0 after reset, then a single {1C,0,0} (a make, not a release); overflow=0.

Source files
------------

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-byte sequencer: folds E0/F0 prefixes into key events, drops control bytes,
// suppresses typematic repeats and queues events in a small FWFT buffer.
module ps2_key_event_ctrl #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   codigo_tecla,
  input  logic                         ready,
  output logic                         evt_valid,
  output logic [7:0]                   evt_code,
  output logic                         evt_ext,
  output logic                         evt_release,
  input  logic                         evt_ack,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CntMax = CW'(TIMEOUT_CYC - 1);
  localparam logic [AW:0]   LvlFull = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  state_e          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [7:0]      r_held_code;
  logic            r_held_ext;
  logic            r_held_valid;
  logic [9:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_level;
  logic            r_overflow;

  logic            w_is_e0, w_is_f0, w_is_ctrl;
  logic            w_evt_req, w_evt_ext, w_evt_rel;
  logic            w_make, w_match, w_push_req, w_push, w_pop, w_full;
  logic [9:0]      w_head;

  assign w_is_e0   = (codigo_tecla == 8'hE0);
  assign w_is_f0   = (codigo_tecla == 8'hF0);
  assign w_is_ctrl = (codigo_tecla == 8'h00) || (codigo_tecla == 8'hAA) ||
                     (codigo_tecla == 8'hEE) || (codigo_tecla == 8'hFA) ||
                     (codigo_tecla == 8'hFC) || (codigo_tecla == 8'hFE) ||
                     (codigo_tecla == 8'hFF);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_evt_req   = 1'b0;
    w_evt_ext   = 1'b0;
    w_evt_rel   = 1'b0;
    if (ready) begin
      w_cnt_nxt = '0;
      case (r_state)
        StIdle: begin
          if (w_is_e0)      w_state_nxt = StExt;
          else if (w_is_f0) w_state_nxt = StBrk;
          else if (!w_is_ctrl) w_evt_req = 1'b1;
        end
        StExt: begin
          if (w_is_f0) w_state_nxt = StExtBrk;
          else if (!w_is_e0) begin
            w_evt_req   = 1'b1;
            w_evt_ext   = 1'b1;
            w_state_nxt = StIdle;
          end
        end
        StBrk: begin
          w_state_nxt = StIdle;
          if (!w_is_e0 && !w_is_f0) begin
            w_evt_req = 1'b1;
            w_evt_rel = 1'b1;
          end
        end
        StExtBrk: begin
          w_state_nxt = StIdle;
          if (!w_is_e0 && !w_is_f0) begin
            w_evt_req = 1'b1;
            w_evt_ext = 1'b1;
            w_evt_rel = 1'b1;
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end else if (r_state == StIdle) begin
      w_cnt_nxt = '0;
    end else if (r_cnt == CntMax) begin
      // Stale prefix: abandon the partial sequence without an event.
      w_state_nxt = StIdle;
      w_cnt_nxt   = '0;
    end else begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  assign w_make     = w_evt_req && !w_evt_rel;
  assign w_match    = r_held_valid && (r_held_code == codigo_tecla) && (r_held_ext == w_evt_ext);
  assign w_push_req = w_evt_req && !(w_make && w_match);
  assign w_full     = (r_level == LvlFull);
  assign w_pop      = evt_ack && (r_level != '0);
  assign w_push     = w_push_req && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_held_code  <= '0;
      r_held_ext   <= 1'b0;
      r_held_valid <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_make && !w_match) begin
        r_held_code  <= codigo_tecla;
        r_held_ext   <= w_evt_ext;
        r_held_valid <= 1'b1;
      end else if (w_evt_req && w_evt_rel && w_match) begin
        r_held_valid <= 1'b0;
      end
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + (AW + 1)'(1);
      else if (w_pop && !w_push) r_level <= r_level - (AW + 1)'(1);
      if (w_push_req && !w_push) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {w_evt_ext, w_evt_rel, codigo_tecla};
  end

  assign w_head      = r_mem[r_rptr];
  assign evt_valid   = (r_level != '0);
  assign evt_code    = evt_valid ? w_head[7:0] : 8'h00;
  assign evt_release = evt_valid ? w_head[8] : 1'b0;
  assign evt_ext     = evt_valid ? w_head[9] : 1'b0;
  assign fifo_level  = r_level;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl with an expected-event scoreboard.
module tb_ps2_key_event_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] codigo_tecla;
  logic       ready;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_release;
  logic       evt_ack;
  logic [2:0] fifo_level;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q[$];

  ps2_key_event_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYC(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .codigo_tecla(codigo_tecla),
    .ready       (ready),
    .evt_valid   (evt_valid),
    .evt_code    (evt_code),
    .evt_ext     (evt_ext),
    .evt_release (evt_release),
    .evt_ack     (evt_ack),
    .fifo_level  (fifo_level),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Pops expectations whenever the DUT is about to pop on the coming edge.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_evt", {22'd0, evt_ext, evt_release, evt_code}, 32'h3FF);
      end else begin
        check("evt", {22'd0, evt_ext, evt_release, evt_code}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send(input logic [7:0] b);
    ready = 1'b1;
    codigo_tecla = b;
    @(posedge clk);
    #1 ready = 1'b0;
    codigo_tecla = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input logic ext, input logic rel, input logic [7:0] code);
    exp_q.push_back({ext, rel, code});
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("level_zero", fifo_level, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; ready = 1'b0; codigo_tecla = 8'h00; evt_ack = 1'b1;
    idle(3);
    @(negedge clk);
    check("rst_valid", evt_valid, 0);
    check("rst_head", {evt_ext, evt_release, evt_code}, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(1);

    // Make/break with one-cycle latency
    expect_evt(1'b0, 1'b0, 8'h1C);
    send(8'h1C);
    @(negedge clk);
    check("lat_make", evt_valid, 1);
    @(posedge clk); #1;
    send(8'hF0);
    expect_evt(1'b0, 1'b1, 8'h1C);
    send(8'h1C);
    @(negedge clk);
    check("lat_break", evt_valid, 1);
    @(posedge clk); #1;
    drain();

    // Extended keys, duplicate prefix, control bytes
    send(8'hE0); expect_evt(1'b1, 1'b0, 8'h75); send(8'h75);
    send(8'hE0); send(8'hF0); expect_evt(1'b1, 1'b1, 8'h75); send(8'h75);
    send(8'hE0); send(8'hE0); expect_evt(1'b1, 1'b0, 8'h75); send(8'h75);
    drain();
    send(8'hAA); send(8'hFA);
    idle(2);
    @(negedge clk);
    check("ctrl_dropped", evt_valid, 0);
    @(posedge clk); #1;

    // Typematic suppression
    expect_evt(1'b0, 1'b0, 8'h1C);
    repeat (5) send(8'h1C);
    send(8'hF0); expect_evt(1'b0, 1'b1, 8'h1C); send(8'h1C);
    expect_evt(1'b0, 1'b0, 8'h1C); send(8'h1C);
    send(8'hF0); expect_evt(1'b0, 1'b1, 8'h1C); send(8'h1C);
    expect_evt(1'b0, 1'b0, 8'h1C); send(8'h1C);
    expect_evt(1'b0, 1'b0, 8'h32); send(8'h32);
    expect_evt(1'b0, 1'b0, 8'h1C); send(8'h1C);
    drain();

    // Overflow and full push+pop
    evt_ack = 1'b0;
    expect_evt(1'b0, 1'b0, 8'h15); send(8'h15);
    expect_evt(1'b0, 1'b0, 8'h1D); send(8'h1D);
    expect_evt(1'b0, 1'b0, 8'h24); send(8'h24);
    expect_evt(1'b0, 1'b0, 8'h2D); send(8'h2D);
    send(8'h2C);
    @(negedge clk);
    check("ovf_level", fifo_level, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_head", {evt_ext, evt_release, evt_code}, 10'h015);
    @(posedge clk); #1;
    evt_ack = 1'b1;
    expect_evt(1'b0, 1'b0, 8'h3C);
    send(8'h3C);
    evt_ack = 1'b0;
    @(negedge clk);
    check("full_pp_level", fifo_level, 4);
    check("full_pp_ovf", overflow, 1);
    check("full_pp_head", evt_code, 8'h1D);
    @(posedge clk); #1;
    evt_ack = 1'b1;
    drain();

    // Prefix timeout
    send(8'hE0); idle(16);
    expect_evt(1'b0, 1'b0, 8'h1C); send(8'h1C);
    drain();
    send(8'hE0); idle(14);
    expect_evt(1'b1, 1'b0, 8'h1C); send(8'h1C);
    drain();

    // Reset mid-operation
    evt_ack = 1'b0;
    send(8'h4D); send(8'h4E); send(8'hF0);
    @(negedge clk);
    check("pre_rst_level", fifo_level, 2);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", evt_valid, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_ovf", overflow, 0);
    @(posedge clk); #1;
    evt_ack = 1'b1;
    expect_evt(1'b0, 1'b0, 8'h1C); send(8'h1C);
    drain();
    check("final_ovf", overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
